spi_reg_bank: RTL and testbench

Register-bank command decoder that sits directly downstream of the SPI slave word interface in the thermocouple design. It consumes each received 16-bit word with its strobe, interprets the first word of every chip-select frame as a command, and then performs register writes or supplies read data as the response word the slave shifts out next. It exports writable control registers to the measurement logic and makes its read-only status words readable over SPI.

---
 rtl/spi_reg_bank.sv | 133 +++++++++++++
 tb/tb_spi_reg_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// Command decoder behind the SPI slave word interface: first word of each frame is a
// command, following words are register write data or clock out prefetched read data.
module spi_reg_bank #(
  parameter int                            WORD_SIZE = 16,
  parameter int                            ADDR_BITS = 3,
  parameter int                            N_RW      = 4,
  parameter int                            N_RO      = 4,
  parameter logic [WORD_SIZE-1:0]          ID_WORD   = 16'hA55A,
  parameter logic [N_RW*WORD_SIZE-1:0]     CTRL_RST  = '0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_frame,
  input  logic [WORD_SIZE-1:0]             i_wdata,
  input  logic                             i_wstb,
  output logic [WORD_SIZE-1:0]             o_wresp,
  output logic [N_RW*WORD_SIZE-1:0]        o_ctrl,
  output logic [N_RW-1:0]                  o_wr_pulse,
  input  logic [N_RO*WORD_SIZE-1:0]        i_status,
  output logic                             o_err
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR, S_RD} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_BITS-1:0]        addr_q, addr_d;
  logic                        inc_q, inc_d;
  logic [WORD_SIZE-1:0]        wresp_q, wresp_d;
  logic [N_RW*WORD_SIZE-1:0]   ctrl_q, ctrl_d;
  logic [N_RW-1:0]             pulse_q, pulse_d;
  logic                        err_q, err_d;

  logic [ADDR_BITS-1:0]        addr_next;
  logic [ADDR_BITS-1:0]        rd_addr;
  logic [WORD_SIZE-1:0]        rd_data;
  logic                        wr_hit;

  assign addr_next = addr_q + ADDR_BITS'(inc_q);

  // The command word reads its own address; later read words prefetch the next one.
  assign rd_addr = (state_q == S_CMD) ? i_wdata[ADDR_BITS-1:0] : addr_next;

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_RW; k++) begin
      if (int'(rd_addr) == k) rd_data = ctrl_q[k*WORD_SIZE +: WORD_SIZE];
    end
    for (int k = 0; k < N_RO; k++) begin
      if (int'(rd_addr) == N_RW + k) rd_data = i_status[k*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inc_d   = inc_q;
    wresp_d = wresp_q;
    ctrl_d  = ctrl_q;
    pulse_d = '0;
    err_d   = err_q;
    wr_hit  = 1'b0;

    // Frame end takes priority over any strobe arriving in the same cycle.
    if (!i_frame) begin
      state_d = S_IDLE;
      addr_d  = '0;
      wresp_d = ID_WORD;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: begin
          if (i_wstb) begin
            addr_d = i_wdata[ADDR_BITS-1:0];
            inc_d  = i_wdata[WORD_SIZE-2];
            if (i_wdata[WORD_SIZE-1]) begin
              state_d = S_WR;
              wresp_d = ID_WORD;
            end else begin
              state_d = S_RD;
              wresp_d = rd_data;
            end
          end
        end
        S_WR: begin
          if (i_wstb) begin
            for (int k = 0; k < N_RW; k++) begin
              if (int'(addr_q) == k) begin
                ctrl_d[k*WORD_SIZE +: WORD_SIZE] = i_wdata;
                pulse_d[k] = 1'b1;
                wr_hit     = 1'b1;
              end
            end
            if (!wr_hit) err_d = 1'b1;
            addr_d = addr_next;
          end
        end
        S_RD: begin
          if (i_wstb) begin
            addr_d  = addr_next;
            wresp_d = rd_data;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      inc_q   <= 1'b0;
      wresp_q <= ID_WORD;
      ctrl_q  <= CTRL_RST;
      pulse_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inc_q   <= inc_d;
      wresp_q <= wresp_d;
      ctrl_q  <= ctrl_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign o_wresp    = wresp_q;
  assign o_ctrl     = ctrl_q;
  assign o_wr_pulse = pulse_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: frame-level model compared every cycle, plus directed literal checks.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame = 1'b0;
  logic [15:0] wdata = '0;
  logic        wstb = 1'b0;
  logic [15:0] wresp;
  logic [63:0] ctrl;
  logic [3:0]  wr_pulse;
  logic [63:0] status = {16'h3333, 16'h2222, 16'h1111, 16'h0777};
  logic        err;

  int errors = 0;
  int checks = 0;

  spi_reg_bank dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_frame    (frame),
    .i_wdata    (wdata),
    .i_wstb     (wstb),
    .o_wresp    (wresp),
    .o_ctrl     (ctrl),
    .o_wr_pulse (wr_pulse),
    .i_status   (status),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  // Frame-level model: word n of a frame (n=0 is the command) targets start+n*INC
  // for reads and start+(n-1)*INC for writes, modulo 8.
  logic        m_open;
  int          m_idx;
  logic [15:0] m_cmd;
  logic [15:0] m_ctrl [4];
  logic [15:0] m_wresp;
  logic [3:0]  m_pulse;
  logic        m_err;

  function automatic logic [15:0] m_rd(input int a);
    if (a < 4) return m_ctrl[a];
    return status[(a-4)*16 +: 16];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_open = 1'b0; m_idx = 0; m_cmd = '0; m_wresp = 16'hA55A;
      m_pulse = '0; m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_ctrl[i] = '0;
    end else begin
      m_pulse = '0;
      if (!frame) begin
        m_open = 1'b0; m_idx = 0; m_wresp = 16'hA55A;
      end else begin
        if (m_open && wstb) begin
          if (m_idx == 0) begin
            m_cmd   = wdata;
            m_wresp = wdata[15] ? 16'hA55A : m_rd(int'(wdata[2:0]));
          end else if (m_cmd[15]) begin
            int a;
            a = (int'(m_cmd[2:0]) + (m_idx - 1) * int'(m_cmd[14])) % 8;
            if (a < 4) begin
              m_ctrl[a] = wdata;
              m_pulse[a] = 1'b1;
            end else m_err = 1'b1;
          end else begin
            m_wresp = m_rd((int'(m_cmd[2:0]) + m_idx * int'(m_cmd[14])) % 8);
          end
          m_idx++;
        end
        m_open = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("model_wresp", {48'h0, wresp}, {48'h0, m_wresp});
    chk("model_ctrl", ctrl, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
    chk("model_pulse", {60'h0, wr_pulse}, {60'h0, m_pulse});
    chk("model_err", {63'h0, err}, {63'h0, m_err});
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic open_frame();
    @(negedge clk); frame = 1'b1;
    idle(2);
  endtask

  task automatic close_frame();
    @(negedge clk); frame = 1'b0;
    idle(2);
  endtask

  task automatic send_word(input logic [15:0] w);
    @(negedge clk); wdata = w; wstb = 1'b1;
    @(negedge clk); wstb = 1'b0;
  endtask

  initial begin
    idle(2);
    rst = 1'b0;

    // Reset state, open frame without strobes
    open_frame();
    chk("reset_wresp", {48'h0, wresp}, 64'hA55A);
    chk("reset_ctrl", ctrl, 64'h0);
    chk("reset_err", {63'h0, err}, 64'h0);
    close_frame();

    // Auto-increment write burst
    open_frame();
    send_word(16'hC001);
    chk("wr_cmd_resp", {48'h0, wresp}, 64'hA55A);
    send_word(16'h1234);
    chk("wr_pulse1", {60'h0, wr_pulse}, 64'h2);
    idle(1);
    chk("wr_pulse1_gone", {60'h0, wr_pulse}, 64'h0);
    send_word(16'hBEEF);
    chk("wr_pulse2", {60'h0, wr_pulse}, 64'h4);
    close_frame();
    chk("wr_ctrl1", {48'h0, ctrl[31:16]}, 64'h1234);
    chk("wr_ctrl2", {48'h0, ctrl[47:32]}, 64'hBEEF);
    chk("wr_err", {63'h0, err}, 64'h0);

    // Back-to-back strobes: ctrl3 then ctrl0 in separate frames
    open_frame();
    @(negedge clk); wdata = 16'h8003; wstb = 1'b1;
    @(negedge clk); wdata = 16'h5A5A;
    @(negedge clk); wstb = 1'b0;
    close_frame();
    open_frame();
    @(negedge clk); wdata = 16'h8000; wstb = 1'b1;
    @(negedge clk); wdata = 16'h0F0F;
    @(negedge clk); wstb = 1'b0;
    close_frame();
    chk("b2b_ctrl", ctrl, 64'h5A5A_BEEF_1234_0F0F);

    // Read burst with prefetch
    open_frame();
    send_word(16'h4002);
    chk("rd_word0", {48'h0, wresp}, 64'hBEEF);
    send_word(16'h0000);
    chk("rd_word1", {48'h0, wresp}, 64'h5A5A);
    send_word(16'h0000);
    chk("rd_word2", {48'h0, wresp}, 64'h0777);
    close_frame();
    chk("idle_wresp", {48'h0, wresp}, 64'hA55A);

    // Address wrap 7 -> 0 with INC, repeat without INC
    open_frame();
    send_word(16'h4007);
    chk("wrap_word0", {48'h0, wresp}, 64'h3333);
    send_word(16'h0000);
    chk("wrap_word1", {48'h0, wresp}, 64'h0F0F);
    close_frame();
    open_frame();
    send_word(16'h0007);
    send_word(16'h0000);
    send_word(16'h0000);
    chk("noinc_word2", {48'h0, wresp}, 64'h3333);
    close_frame();

    // Write to a status address: ignored and sticky error
    open_frame();
    send_word(16'h8005);
    send_word(16'h1111);
    chk("ro_pulse", {60'h0, wr_pulse}, 64'h0);
    chk("ro_err", {63'h0, err}, 64'h1);
    close_frame();
    chk("ro_ctrl", ctrl, 64'h5A5A_BEEF_1234_0F0F);
    open_frame();
    chk("ro_err_sticky", {63'h0, err}, 64'h1);
    close_frame();

    // Frame drop in the same cycle as a data strobe
    open_frame();
    send_word(16'h8001);
    @(negedge clk); wdata = 16'hDEAD; wstb = 1'b1; frame = 1'b0;
    @(negedge clk); wstb = 1'b0;
    chk("drop_pulse", {60'h0, wr_pulse}, 64'h0);
    idle(2);
    chk("drop_ctrl1", {48'h0, ctrl[31:16]}, 64'h1234);
    open_frame();
    send_word(16'h4001);
    chk("drop_next_cmd", {48'h0, wresp}, 64'h1234);
    close_frame();

    // Asynchronous reset in the middle of a write burst
    open_frame();
    send_word(16'hC000);
    send_word(16'h7777);
    chk("pre_rst_ctrl0", {48'h0, ctrl[15:0]}, 64'h7777);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", ctrl, 64'h0);
    chk("async_rst_wresp", {48'h0, wresp}, 64'hA55A);
    @(negedge clk); rst = 1'b0;
    idle(2);
    send_word(16'h4001);
    chk("post_rst_read", {48'h0, wresp}, 64'h0);
    chk("post_rst_err", {63'h0, err}, 64'h0);
    close_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
